bus_xbar_rr: RTL and testbench
==============================

Name: bus_xbar_rr

Overview:
- Parametrised request/grant memory-mapped crossbar for the SoC fabric: NB_MASTER initiators (core data, debug, SPI-slave DMA, ...) to NB_SLAVE targets (instr mem, data mem, peripheral bus, ...).
- Replaces the fixed 3x3 node with configurable master/slave counts and a configurable address map.
- Arbitration is round-robin per slave. Unmapped accesses get an in-fabric error response.

Parameters:
- NB_MASTER, 3, number of initiator ports (>=1)
- NB_SLAVE, 3, number of target ports (>=1)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (multiple of 8)
- START_ADDR, {32'h1A10_0000,32'h0010_0000,32'h0000_0000}, packed [NB_SLAVE-1:0][ADDR_WIDTH-1:0] inclusive region base
- END_ADDR, {32'h1A11_FFFF,32'h001F_FFFF,32'h000F_FFFF}, packed inclusive region end
- TIMEOUT_CYCLES, 256, response watchdog limit (used only with BUS_XBAR_TIMEOUT_EN)

Ports:
- clk  in  1  fabric clock
- rst  in  1  synchronous active-high reset
- m_req_i  in  NB_MASTER  master request
- m_addr_i  in  NB_MASTER x ADDR_WIDTH  byte address
- m_we_i  in  NB_MASTER  1=write
- m_be_i  in  NB_MASTER x DATA_WIDTH/8  byte enables
- m_wdata_i  in  NB_MASTER x DATA_WIDTH  write data
- m_gnt_o  out  NB_MASTER  request accepted
- m_rvalid_o  out  NB_MASTER  response valid
- m_rdata_o  out  NB_MASTER x DATA_WIDTH  read data
- m_err_o  out  NB_MASTER  error response, qualified by m_rvalid_o
- s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o  out  NB_SLAVE x (1/AW/1/DW/8/DW)  forwarded request
- s_gnt_i  in  NB_SLAVE  slave accepted
- s_rvalid_i  in  NB_SLAVE  slave response
- s_rdata_i  in  NB_SLAVE x DATA_WIDTH  slave read data
- s_err_i  in  NB_SLAVE  slave error

Behaviour:
- Single clock `clk`. `rst` is synchronous, active-high.
- Reset values:
  - All gnt/rvalid/err/req outputs are 0; all data outputs are 0.
  - Every slave FSM is IDLE.
  - Every RR pointer is 0.
- Decode (combinational): a master targets the lowest-index slave with START_ADDR[s] <= addr <= END_ADDR[s]. No hit means the error target.
- Per-slave FSM:
  - IDLE: with >=1 requesting master decoded to this slave, the round-robin winner's request is driven combinationally onto s_*_o.
    - s_gnt_i=1: m_gnt_o[winner]=1 the same cycle; owner latched; go BUSY; pointer = winner+1 (wraps at NB_MASTER).
    - s_gnt_i=0: the request is held. The winner may change next cycle only if the winner drops m_req_i.
  - BUSY: s_req_o=0. On s_rvalid_i, forward rvalid/rdata/err to the owner in the same cycle (combinational), then go IDLE.
  - One outstanding transaction per slave, in order.
- Round-robin: start the search at the pointer. The pointer advances only on a grant.
- Error target: an unmapped request is granted immediately (same cycle, no arbitration with slaves). The next cycle gives m_rvalid_o=1, m_err_o=1, m_rdata_o=32'hBADACCE5 (zero-extended or truncated to DATA_WIDTH).
- Masters:
  - Must hold req/addr/data stable until gnt.
  - Must not issue a new request before rvalid of the previous one. Violation is undefined; the bench asserts it.
- Simultaneous events: rvalid and a new IDLE grant cannot coincide on the same slave. The BUSY to IDLE transition costs 0 cycles of forward latency but 1 cycle before the next grant.
- Reset mid-transaction: all state clears. Late s_rvalid_i arriving in IDLE is ignored and flagged by an assertion.
- Latency: request to slave is 0 cycles; response is 0 cycles added.

Optional Feature:
- Macro BUS_XBAR_TIMEOUT_EN.
- Defined:
  - Each slave FSM has a $clog2(TIMEOUT_CYCLES+1)-bit counter, cleared on grant and incremented in BUSY.
  - When it reaches TIMEOUT_CYCLES without s_rvalid_i, the owner gets m_rvalid_o=1, m_err_o=1, rdata=32'hDEAD_71ED, and the FSM goes to DRAIN.
  - DRAIN swallows the next s_rvalid_i without forwarding, then goes IDLE.
  - rvalid in the same cycle as timeout: the real response wins.
- Undefined: no counters and no DRAIN state. BUSY waits indefinitely.

Decomposition:
- Package bus_xbar_pkg:
  - slave_state_e {IDLE, BUSY, DRAIN}
  - ERR_RDATA and TIMEOUT_RDATA constants
  - decode function addr -> target index, with NB_SLAVE meaning error
- Sub-module rr_arbiter (NB_REQ parameter): req vector, advance strobe, one-hot grant, pointer register. One instance per slave.

Test Plan:
- Reset, then M0 read 0x0010_0004, S1 gnt same cycle, rvalid 3 cycles later with 0x1234_5678 -> M0 gnt at cycle 0, rvalid+rdata 0x1234_5678 at cycle 3, err=0.
- M0, M1, M2 all request S2 continuously, slave always grants and responds next cycle -> grant order 0,1,2,0,1,2; no master is starved.
- M1 writes 0x2000_0000 (unmapped) -> gnt same cycle, next cycle rvalid=1, err=1, rdata=0xBADACCE5; slave req lines stay 0.
- M0->S0 and M1->S2 issued in the same cycle -> both granted the same cycle, responses independent.
- Assert rst while S1 is BUSY, then S1 rvalid arrives -> no m_rvalid_o pulse; the next request is granted normally.
- (BUS_XBAR_TIMEOUT_EN, TIMEOUT_CYCLES=8) S0 never responds -> rvalid/err with 0xDEAD71ED 8 cycles after grant. A late rvalid is swallowed; the next request is served.

Source files
------------

// File: rtl/bus_xbar_pkg.sv
// Shared types, response constants and address decode for bus_xbar_rr.
package bus_xbar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } slave_state_e;

  localparam logic [31:0] ERR_RDATA     = 32'hBADA_CCE5;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_71ED;

  // Upper bounds for the decode arguments; callers zero-extend into these.
  localparam int MAX_AW    = 64;
  localparam int MAX_SLAVE = 16;

  // Lowest-index matching region wins; nb_slave means "no region hit".
  function automatic int decode(input logic [MAX_AW-1:0] addr,
                                input logic [MAX_SLAVE-1:0][MAX_AW-1:0] lo,
                                input logic [MAX_SLAVE-1:0][MAX_AW-1:0] hi,
                                input int nb_slave);
    decode = nb_slave;
    for (int s = MAX_SLAVE - 1; s >= 0; s--) begin
      if (s < nb_slave && addr >= lo[s] && addr <= hi[s]) decode = s;
    end
  endfunction

endpackage

// File: rtl/bus_xbar_rr_arbiter.sv
// Round-robin arbiter with grant lock: a presented-but-unaccepted winner
// stays selected while it keeps requesting; the pointer moves only on advance.
module rr_arbiter #(
  parameter int NB_REQ = 3,
  parameter int IW     = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NB_REQ-1:0] req,
  input  logic              advance,
  output logic [NB_REQ-1:0] gnt,
  output logic [IW-1:0]     idx
);

  logic [IW-1:0]     ptr;
  logic              locked;
  logic [NB_REQ-1:0] lock_oh;
  logic [NB_REQ-1:0] pick;

  always_comb begin
    pick = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (pick == '0 && req[(int'(ptr) + i) % NB_REQ]) pick[(int'(ptr) + i) % NB_REQ] = 1'b1;
    end
    gnt = (locked && |(req & lock_oh)) ? lock_oh : pick;
    idx = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (gnt[i]) idx = IW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      locked  <= 1'b0;
      lock_oh <= '0;
    end else begin
      locked  <= |gnt && !advance;
      lock_oh <= gnt;
      if (advance) ptr <= (idx == IW'(NB_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/bus_xbar_rr.sv
// NB_MASTER x NB_SLAVE request/grant crossbar, round-robin per slave, one
// outstanding transaction per slave. Optional watchdog: BUS_XBAR_TIMEOUT_EN.
module bus_xbar_rr
  import bus_xbar_pkg::*;
#(
  parameter int NB_MASTER      = 3,
  parameter int NB_SLAVE       = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0] START_ADDR =
    {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000},
  parameter logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0] END_ADDR =
    {32'h1A11_FFFF, 32'h001F_FFFF, 32'h000F_FFFF},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NB_MASTER-1:0]                  m_req_i,
  input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NB_MASTER-1:0]                  m_we_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NB_MASTER-1:0][DATA_WIDTH-1:0]  m_wdata_i,
  output logic [NB_MASTER-1:0]                  m_gnt_o,
  output logic [NB_MASTER-1:0]                  m_rvalid_o,
  output logic [NB_MASTER-1:0][DATA_WIDTH-1:0]  m_rdata_o,
  output logic [NB_MASTER-1:0]                  m_err_o,
  output logic [NB_SLAVE-1:0]                   s_req_o,
  output logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]   s_addr_o,
  output logic [NB_SLAVE-1:0]                   s_we_o,
  output logic [NB_SLAVE-1:0][DATA_WIDTH/8-1:0] s_be_o,
  output logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]   s_wdata_o,
  input  logic [NB_SLAVE-1:0]                   s_gnt_i,
  input  logic [NB_SLAVE-1:0]                   s_rvalid_i,
  input  logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]   s_rdata_i,
  input  logic [NB_SLAVE-1:0]                   s_err_i
);

  localparam int MW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;

  logic [MAX_SLAVE-1:0][MAX_AW-1:0] start_x, end_x;
  int                   tgt [NB_MASTER];
  slave_state_e         state [NB_SLAVE];
  logic [MW-1:0]        owner [NB_SLAVE];
  logic [NB_MASTER-1:0] arb_req [NB_SLAVE];
  logic [NB_MASTER-1:0] arb_gnt [NB_SLAVE];
  logic [MW-1:0]        arb_idx [NB_SLAVE];
  logic [NB_SLAVE-1:0]  acc, fwd, tmo;
  logic [NB_MASTER-1:0] err_pend;
`ifdef BUS_XBAR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]        cnt [NB_SLAVE];
`endif

  always_comb begin
    start_x = '0;
    end_x   = '0;
    for (int s = 0; s < NB_SLAVE; s++) begin
      start_x[s] = MAX_AW'(START_ADDR[s]);
      end_x[s]   = MAX_AW'(END_ADDR[s]);
    end
    for (int m = 0; m < NB_MASTER; m++) begin
      tgt[m] = decode(MAX_AW'(m_addr_i[m]), start_x, end_x, NB_SLAVE);
    end
    for (int s = 0; s < NB_SLAVE; s++) begin
      for (int m = 0; m < NB_MASTER; m++) begin
        arb_req[s][m] = m_req_i[m] && tgt[m] == s && state[s] == IDLE && !rst;
      end
    end
  end

  for (genvar s = 0; s < NB_SLAVE; s++) begin : g_arb
    rr_arbiter #(.NB_REQ(NB_MASTER), .IW(MW)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (arb_req[s]),
      .advance (acc[s]),
      .gnt     (arb_gnt[s]),
      .idx     (arb_idx[s])
    );
  end

  always_comb begin
    s_req_o   = '0;
    s_addr_o  = '0;
    s_we_o    = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    acc       = '0;
    fwd       = '0;
    tmo       = '0;
    for (int s = 0; s < NB_SLAVE; s++) begin
      s_req_o[s] = |arb_gnt[s];
      if (s_req_o[s]) begin
        s_addr_o[s]  = m_addr_i[arb_idx[s]];
        s_we_o[s]    = m_we_i[arb_idx[s]];
        s_be_o[s]    = m_be_i[arb_idx[s]];
        s_wdata_o[s] = m_wdata_i[arb_idx[s]];
      end
      acc[s] = s_req_o[s] && s_gnt_i[s];
      fwd[s] = state[s] == BUSY && s_rvalid_i[s] && !rst;
`ifdef BUS_XBAR_TIMEOUT_EN
      // A real response in the expiry cycle takes precedence.
      tmo[s] = state[s] == BUSY && !s_rvalid_i[s] && !rst &&
               cnt[s] == TW'(TIMEOUT_CYCLES - 1);
`endif
    end
  end

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = '0;
    for (int m = 0; m < NB_MASTER; m++) begin
      m_gnt_o[m] = m_req_i[m] && tgt[m] == NB_SLAVE && !rst;
      if (err_pend[m] && !rst) begin
        m_rvalid_o[m] = 1'b1;
        m_err_o[m]    = 1'b1;
        m_rdata_o[m]  = DATA_WIDTH'(ERR_RDATA);
      end
      for (int s = 0; s < NB_SLAVE; s++) begin
        if (acc[s] && arb_gnt[s][m]) m_gnt_o[m] = 1'b1;
        if (fwd[s] && owner[s] == MW'(m)) begin
          m_rvalid_o[m] = 1'b1;
          m_err_o[m]    = s_err_i[s];
          m_rdata_o[m]  = s_rdata_i[s];
        end
        if (tmo[s] && owner[s] == MW'(m)) begin
          m_rvalid_o[m] = 1'b1;
          m_err_o[m]    = 1'b1;
          m_rdata_o[m]  = DATA_WIDTH'(TIMEOUT_RDATA);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_pend <= '0;
      for (int s = 0; s < NB_SLAVE; s++) begin
        state[s] <= IDLE;
        owner[s] <= '0;
`ifdef BUS_XBAR_TIMEOUT_EN
        cnt[s]   <= '0;
`endif
      end
    end else begin
      for (int m = 0; m < NB_MASTER; m++) begin
        err_pend[m] <= m_req_i[m] && tgt[m] == NB_SLAVE;
      end
      for (int s = 0; s < NB_SLAVE; s++) begin
        case (state[s])
          IDLE: if (acc[s]) begin
            state[s] <= BUSY;
            owner[s] <= arb_idx[s];
`ifdef BUS_XBAR_TIMEOUT_EN
            cnt[s]   <= '0;
`endif
          end
          BUSY: begin
            if (s_rvalid_i[s]) state[s] <= IDLE;
`ifdef BUS_XBAR_TIMEOUT_EN
            else if (tmo[s]) state[s] <= DRAIN;
            else cnt[s] <= cnt[s] + 1'b1;
`endif
          end
          DRAIN: if (s_rvalid_i[s]) state[s] <= IDLE;
          default: state[s] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_xbar_rr.sv
// Directed bench for bus_xbar_rr; responses checked against a per-master queue.
module tb_bus_xbar_rr;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       m_req_i, m_we_i, m_gnt_o, m_rvalid_o, m_err_o;
  logic [2:0][31:0] m_addr_i, m_wdata_i, m_rdata_o;
  logic [2:0][3:0]  m_be_i;
  logic [2:0]       s_req_o, s_we_o, s_gnt_i, s_rvalid_i, s_err_i;
  logic [2:0][31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic [2:0][3:0]  s_be_o;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } rsp_t;

  rsp_t sbq [3][$];
  int   total = 0;
  int   bad   = 0;

  bus_xbar_rr #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
    .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .s_err_i(s_err_i)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: every response seen must match the head of that master's queue.
  task automatic mid();
    rsp_t r;
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      if (m_rvalid_o[m] !== 1'b0) begin
        if (sbq[m].size() == 0) check($sformatf("unexpected_rvalid_m%0d", m), m_rvalid_o[m], 0);
        else begin
          r = sbq[m].pop_front();
          check($sformatf("rdata_m%0d", m), m_rdata_o[m], r.d);
          check($sformatf("err_m%0d", m), m_err_o[m], r.e);
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int m, input logic [31:0] d, input logic e);
    rsp_t r;
    r.d = d;
    r.e = e;
    sbq[m].push_back(r);
  endtask

  initial begin
    rst = 1'b1;
    m_req_i = 3'b111; m_we_i = '0; m_be_i = '1; m_wdata_i = '0;
    m_addr_i = {32'h1A10_0000, 32'h0010_0000, 32'h0000_0000};
    s_gnt_i = 3'b111; s_rvalid_i = 3'b111; s_rdata_i = '1; s_err_i = '0;

    // Reset: requests and slave responses present, everything must stay quiet.
    adv(); adv(); mid();
    check("rst_gnt", m_gnt_o, 0);
    check("rst_rvalid", m_rvalid_o, 0);
    check("rst_sreq", s_req_o, 0);
    check("rst_saddr", s_addr_o, 0);
    check("rst_rdata", m_rdata_o, 0);
    adv();
    rst = 1'b0; m_req_i = '0; s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0;

    // M0 read to S1, response three cycles after grant.
    m_req_i[0] = 1'b1; m_addr_i[0] = 32'h0010_0004; s_gnt_i[1] = 1'b1;
    push(0, 32'h1234_5678, 1'b0);
    mid();
    check("t1_gnt", m_gnt_o, 3'b001);
    check("t1_sreq", s_req_o, 3'b010);
    check("t1_saddr", s_addr_o[1], 32'h0010_0004);
    adv(); m_req_i = '0; s_gnt_i = '0;
    mid(); adv(); mid(); adv();
    s_rvalid_i[1] = 1'b1; s_rdata_i[1] = 32'h1234_5678;
    mid(); check("t1_rvalid", m_rvalid_o, 3'b001);
    adv(); s_rvalid_i = '0; s_rdata_i = '0;

    // Stalled slave: M2 presented, M1 joins later but must not displace it.
    m_req_i[2] = 1'b1; m_addr_i[2] = 32'h0010_0010; m_we_i[2] = 1'b1; m_wdata_i[2] = 32'hAA;
    mid();
    check("hold_sreq", s_req_o, 3'b010);
    check("hold_gnt0", m_gnt_o, 0);
    adv(); m_req_i[1] = 1'b1; m_addr_i[1] = 32'h0010_0020;
    mid();
    check("hold_saddr", s_addr_o[1], 32'h0010_0010);
    check("hold_swe", s_we_o[1], 1);
    check("hold_swdata", s_wdata_o[1], 32'hAA);
    adv(); s_gnt_i[1] = 1'b1;
    mid(); check("hold_gnt_m2", m_gnt_o, 3'b100);
    push(2, 32'h0, 1'b0);
    adv(); m_req_i[2] = 1'b0; m_we_i = '0; s_gnt_i[1] = 1'b0; s_rvalid_i[1] = 1'b1;
    mid();
    adv(); s_rvalid_i = '0; s_gnt_i[1] = 1'b1;
    mid(); check("hold_gnt_m1", m_gnt_o, 3'b010);
    push(1, 32'h55, 1'b0);
    adv(); m_req_i = '0; s_gnt_i = '0; s_rvalid_i[1] = 1'b1; s_rdata_i[1] = 32'h55;
    mid();
    adv(); s_rvalid_i = '0; s_rdata_i = '0;

    // All masters hammer S2: grants must rotate 0,1,2,0,1,2.
    m_req_i = 3'b111; m_addr_i = {3{32'h1A10_0100}}; s_gnt_i[2] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mid();
      check($sformatf("rr_order_%0d", k), m_gnt_o, 128'(1) << (k % 3));
      push(k % 3, 32'hC0DE_0000 + k, 1'b0);
      adv(); m_req_i[k % 3] = 1'b0; s_rvalid_i[2] = 1'b1; s_rdata_i[2] = 32'hC0DE_0000 + k;
      mid(); check($sformatf("rr_busy_nognt_%0d", k), m_gnt_o, 0);
      adv(); s_rvalid_i = '0; m_req_i[k % 3] = 1'b1;
    end
    m_req_i = '0; s_gnt_i = '0; s_rdata_i = '0;

    // Unmapped write from M1: in-fabric error response.
    m_req_i[1] = 1'b1; m_addr_i[1] = 32'h2000_0000; m_we_i[1] = 1'b1;
    mid();
    check("unm_gnt", m_gnt_o, 3'b010);
    check("unm_sreq", s_req_o, 0);
    push(1, 32'hBADA_CCE5, 1'b1);
    adv(); m_req_i = '0; m_we_i = '0;
    mid(); check("unm_sreq2", s_req_o, 0);
    adv();

    // Concurrent M0->S0 and M1->S2, responses on different cycles.
    m_req_i = 3'b011; m_addr_i[0] = 32'h0000_0040; m_addr_i[1] = 32'h1A10_0000; s_gnt_i = 3'b101;
    mid();
    check("par_gnt", m_gnt_o, 3'b011);
    check("par_sreq", s_req_o, 3'b101);
    push(0, 32'hB0B0, 1'b1);
    push(1, 32'hA1A1, 1'b0);
    adv(); m_req_i = '0; s_gnt_i = '0; s_rvalid_i[2] = 1'b1; s_rdata_i[2] = 32'hA1A1;
    mid();
    adv(); s_rvalid_i = '0; s_rvalid_i[0] = 1'b1; s_rdata_i[0] = 32'hB0B0; s_err_i[0] = 1'b1;
    mid();
    adv(); s_rvalid_i = '0; s_rdata_i = '0; s_err_i = '0;

    // Reset while S1 is busy; the late response must be dropped.
    m_req_i[0] = 1'b1; m_addr_i[0] = 32'h0010_0000; s_gnt_i[1] = 1'b1;
    mid(); check("rmid_gnt", m_gnt_o, 3'b001);
    adv(); m_req_i = '0; s_gnt_i = '0; rst = 1'b1;
    mid();
    adv(); rst = 1'b0; s_rvalid_i[1] = 1'b1; s_rdata_i[1] = 32'hDEAD;
    mid(); check("rmid_no_rvalid", m_rvalid_o, 0);
    adv(); s_rvalid_i = '0; m_req_i[2] = 1'b1; m_addr_i[2] = 32'h0010_0008; s_gnt_i[1] = 1'b1;
    mid(); check("rmid_regnt", m_gnt_o, 3'b100);
    push(2, 32'h77, 1'b0);
    adv(); m_req_i = '0; s_gnt_i = '0; s_rvalid_i[1] = 1'b1; s_rdata_i[1] = 32'h77;
    mid();
    adv(); s_rvalid_i = '0; s_rdata_i = '0;

`ifdef BUS_XBAR_TIMEOUT_EN
    // S0 silent: watchdog answers 8 cycles after grant, late response swallowed.
    m_req_i[0] = 1'b1; m_addr_i[0] = 32'h0000_0000; s_gnt_i[0] = 1'b1;
    mid(); check("to_gnt", m_gnt_o, 3'b001);
    push(0, 32'hDEAD_71ED, 1'b1);
    adv(); m_req_i = '0; s_gnt_i = '0;
    for (int i = 1; i < 8; i++) begin
      mid(); check($sformatf("to_wait_%0d", i), m_rvalid_o, 0);
      adv();
    end
    mid(); check("to_fire", m_rvalid_o, 3'b001);
    adv(); s_rvalid_i[0] = 1'b1; s_rdata_i[0] = 32'h1111;
    mid(); check("to_swallow", m_rvalid_o, 0);
    adv(); s_rvalid_i = '0; m_req_i[1] = 1'b1; m_addr_i[1] = 32'h0000_0010; s_gnt_i[0] = 1'b1;
    mid(); check("to_next_gnt", m_gnt_o, 3'b010);
    push(1, 32'h2222, 1'b0);
    adv(); m_req_i = '0; s_gnt_i = '0; s_rvalid_i[0] = 1'b1; s_rdata_i[0] = 32'h2222;
    mid();
    adv(); s_rvalid_i = '0; s_rdata_i = '0;
`endif

    for (int m = 0; m < 3; m++) check($sformatf("sb_empty_m%0d", m), sbq[m].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
